core_task_dispatcher: RTL and testbench

Requester-side counterpart of the core allocator (`core_simple_assignment`). It accepts tasks from an upstream valid/ready stream and requests a free core from the allocator. Each task is issued to the granted core with a one-cycle start strobe. When that core reports completion, the dispatcher returns the core to the allocator through the release port. It sits between the task front-end and the core array and owns both ends of the allocator's request/grant/release protocol.

---
 rtl/core_dispatch_pkg.sv | 22 ++
 rtl/core_task_dispatcher_if.sv | 46 ++++
 rtl/core_release_arbiter.sv | 38 +++
 rtl/core_task_dispatcher.sv | 146 ++++++++++++++
 tb/tb_core_task_dispatcher.sv | 193 +++++++++++++++++++
 5 files changed

// File: rtl/core_dispatch_pkg.sv
// ----------------------------------------------------------------------------
// core_dispatch_pkg
// Shared types and helpers for the core task dispatcher slice.
//   dispatch_state_t : dispatch FSM encoding (IDLE, REQ, WAIT, START)
//   core_id_w()      : width of an encoded core id for a given core count
// ----------------------------------------------------------------------------
package core_dispatch_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    REQ   = 2'd1,
    WAIT  = 2'd2,
    START = 2'd3
  } dispatch_state_t;

  // Never narrower than one bit, so a degenerate core count still has a
  // legal id vector.
  function automatic int core_id_w(input int cores);
    return (cores > 1) ? $clog2(cores) : 1;
  endfunction

endpackage

// File: rtl/core_task_dispatcher_if.sv
// ----------------------------------------------------------------------------
// core_task_dispatcher_if
// Bundles the three handshakes the dispatcher owns:
//   task stream : task_valid, task_data -> task_ready
//   allocator   : core_request, core_release, released_core_id <-> core_valid, core_id
//   core array  : core_start, core_task, busy_mask <-> core_done
// Modports:
//   master : the dispatcher itself
//   slave  : the environment (front-end, allocator and cores)
// ----------------------------------------------------------------------------
interface core_task_dispatcher_if #(
  parameter int CORES  = 4,
  parameter int TASK_W = 32
) ();
  import core_dispatch_pkg::*;

  localparam int ID_W = core_id_w(CORES);

  logic              task_valid;
  logic [TASK_W-1:0] task_data;
  logic              task_ready;

  logic              core_request;
  logic              core_valid;
  logic [ID_W-1:0]   core_id;
  logic              core_release;
  logic [ID_W-1:0]   released_core_id;

  logic [CORES-1:0]  core_start;
  logic [TASK_W-1:0] core_task;
  logic [CORES-1:0]  core_done;
  logic [CORES-1:0]  busy_mask;

  modport master (
    input  task_valid, task_data, core_valid, core_id, core_done,
    output task_ready, core_request, core_release, released_core_id,
           core_start, core_task, busy_mask
  );

  modport slave (
    output task_valid, task_data, core_valid, core_id, core_done,
    input  task_ready, core_request, core_release, released_core_id,
           core_start, core_task, busy_mask
  );

endinterface

// File: rtl/core_release_arbiter.sv
// ----------------------------------------------------------------------------
// core_release_arbiter
// Purely combinational fixed-priority picker: lowest-index set bit wins.
//   pending : mask of cores waiting to be released
//   sel     : one-hot select of the winner (0 when nothing pending)
//   id      : encoded index of the winner (0 when nothing pending)
//   valid   : at least one bit pending
// ----------------------------------------------------------------------------
module core_release_arbiter
  import core_dispatch_pkg::*;
#(
  parameter int CORES = 4,
  localparam int ID_W = core_id_w(CORES)
) (
  input  logic [CORES-1:0] pending,
  output logic [CORES-1:0] sel,
  output logic [ID_W-1:0]  id,
  output logic             valid
);

  // NOTE: every output gets a default before the loop; a path that leaves a
  // combinational output unassigned would infer a latch.
  always_comb begin
    sel   = '0;
    id    = '0;
    valid = 1'b0;
    // Scan downwards so the lowest pending index is the last one written.
    for (int i = CORES - 1; i >= 0; i--) begin
      if (pending[i]) begin
        sel    = '0;
        sel[i] = 1'b1;
        id     = ID_W'(i);
        valid  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/core_task_dispatcher.sv
// ----------------------------------------------------------------------------
// core_task_dispatcher
// Accepts tasks from a valid/ready stream, requests a core from the allocator,
// starts the granted core with a one-cycle strobe and returns cores to the
// allocator once they report completion (one release per cycle, lowest index
// first).
// Ports:
//   clk      : single clock, rising edge
//   reset_n  : asynchronous active-low reset
//   bus      : core_task_dispatcher_if.master (task stream, allocator, cores)
// Optional build macro CORE_DISPATCH_STATS_EN adds:
//   dispatch_count : 32-bit count of START cycles (wraps)
//   release_count  : 32-bit count of core_release pulses (wraps)
// ----------------------------------------------------------------------------
module core_task_dispatcher
  import core_dispatch_pkg::*;
#(
  parameter int CORES  = 4,
  parameter int TASK_W = 32
) (
  input  logic                   clk,
  input  logic                   reset_n,
  core_task_dispatcher_if.master bus
`ifdef CORE_DISPATCH_STATS_EN
  ,
  output logic [31:0]            dispatch_count,
  output logic [31:0]            release_count
`endif
);

  localparam int ID_W = core_id_w(CORES);
  localparam logic [CORES-1:0] ONE_HOT_0 = CORES'(1);

  dispatch_state_t   state;
  logic [TASK_W-1:0] task_q;
  logic [ID_W-1:0]   id_q;
  logic              request_q;
  logic [CORES-1:0]  start_q;
  logic [TASK_W-1:0] core_task_q;

  logic [CORES-1:0]  done_pending_q;
  logic [CORES-1:0]  busy_q;
  logic              release_q;
  logic [ID_W-1:0]   release_id_q;

  logic [CORES-1:0]  pending_eff;
  logic [CORES-1:0]  rel_sel;
  logic [ID_W-1:0]   rel_id;
  logic              rel_valid;
  logic [CORES-1:0]  start_set;

  // ---------------------------------------------------------------- dispatch
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  // NOTE: only control and datapath registers are reset here; there is no
  // memory array, so everything can be cleared asynchronously.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= IDLE;
      task_q      <= '0;
      id_q        <= '0;
      request_q   <= 1'b0;
      start_q     <= '0;
      core_task_q <= '0;
`ifdef CORE_DISPATCH_STATS_EN
      dispatch_count <= '0;
`endif
    end else begin
      request_q <= 1'b0;
      start_q   <= '0;
      case (state)
        IDLE: begin
          // task_ready is high throughout IDLE, so task_valid alone accepts.
          if (bus.task_valid) begin
            task_q    <= bus.task_data;
            request_q <= 1'b1;
            state     <= REQ;
          end
        end
        REQ: state <= WAIT;
        WAIT: begin
          // No timeout: the allocator always answers a request eventually.
          if (bus.core_valid) begin
            id_q        <= bus.core_id;
            start_q     <= ONE_HOT_0 << bus.core_id;
            core_task_q <= task_q;
            state       <= START;
          end
        end
        START: begin
          state <= IDLE;
`ifdef CORE_DISPATCH_STATS_EN
          dispatch_count <= dispatch_count + 32'd1;
`endif
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Busy bit for the started core is set on the edge that leaves START.
  assign start_set = (state == START) ? (ONE_HOT_0 << id_q) : '0;

  // ----------------------------------------------------------------- release
  // A done pulse is folded in on the same edge it arrives so the release can
  // go out in the very next cycle; done from a non-busy core is dropped.
  assign pending_eff = done_pending_q | (bus.core_done & busy_q);

  core_release_arbiter #(.CORES(CORES)) u_release_arbiter (
    .pending (pending_eff),
    .sel     (rel_sel),
    .id      (rel_id),
    .valid   (rel_valid)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      done_pending_q <= '0;
      busy_q         <= '0;
      release_q      <= 1'b0;
      release_id_q   <= '0;
`ifdef CORE_DISPATCH_STATS_EN
      release_count  <= '0;
`endif
    end else begin
      done_pending_q <= pending_eff & ~rel_sel;
      // Set wins over clear if a core is restarted while still marked busy.
      busy_q         <= (busy_q & ~rel_sel) | start_set;
      release_q      <= rel_valid;
      release_id_q   <= rel_id;
`ifdef CORE_DISPATCH_STATS_EN
      if (rel_valid) release_count <= release_count + 32'd1;
`endif
    end
  end

  // ----------------------------------------------------------------- outputs
  assign bus.task_ready       = (state == IDLE);
  assign bus.core_request     = request_q;
  assign bus.core_start       = start_q;
  assign bus.core_task        = core_task_q;
  assign bus.core_release     = release_q;
  assign bus.released_core_id = release_id_q;
  assign bus.busy_mask        = busy_q;

endmodule

// File: tb/tb_core_task_dispatcher.sv
// ----------------------------------------------------------------------------
// tb_core_task_dispatcher
// Directed self-checking bench for core_task_dispatcher (CORES=4, TASK_W=32).
// Inputs are driven and outputs sampled 1 time unit after each rising edge.
// ----------------------------------------------------------------------------
module tb_core_task_dispatcher;

  logic clk;
  logic reset_n;
  int   checks   = 0;
  int   failures = 0;

  core_task_dispatcher_if #(.CORES(4), .TASK_W(32)) bus ();

`ifdef CORE_DISPATCH_STATS_EN
  logic [31:0] dispatch_count;
  logic [31:0] release_count;
`endif

  core_task_dispatcher #(.CORES(4), .TASK_W(32)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
`ifdef CORE_DISPATCH_STATS_EN
    ,
    .dispatch_count (dispatch_count),
    .release_count  (release_count)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Full dispatch: accept, request, `delay` idle WAIT cycles, grant, start.
  task automatic dispatch(input logic [31:0] data, input logic [1:0] id,
                          input int delay, input logic [3:0] busy_exp);
    int req_seen;
    int ready_seen;
    bus.task_valid = 1'b1;
    bus.task_data  = data;
    tick();
    bus.task_valid = 1'b0;
    check("req_pulse", 64'(bus.core_request), 64'd1);
    check("ready_in_req", 64'(bus.task_ready), 64'd0);
    tick();
    check("req_one_cycle", 64'(bus.core_request), 64'd0);
    req_seen   = 0;
    ready_seen = 0;
    for (int i = 0; i < delay; i++) begin
      tick();
      if (bus.core_request) req_seen++;
      if (bus.task_ready)   ready_seen++;
    end
    check("no_second_req", 64'(req_seen), 64'd0);
    check("ready_low_in_wait", 64'(ready_seen), 64'd0);
    bus.core_valid = 1'b1;
    bus.core_id    = id;
    tick();
    bus.core_valid = 1'b0;
    check("core_start", 64'(bus.core_start), 64'(4'b0001 << id));
    check("core_task", 64'(bus.core_task), 64'(data));
    tick();
    check("start_cleared", 64'(bus.core_start), 64'd0);
    check("busy_after_start", 64'(bus.busy_mask), 64'(busy_exp));
    check("ready_back", 64'(bus.task_ready), 64'd1);
  endtask

  initial begin
    reset_n        = 1'b0;
    bus.task_valid = 1'b0;
    bus.task_data  = '0;
    bus.core_valid = 1'b0;
    bus.core_id    = '0;
    bus.core_done  = '0;

    // Reset sequence.
    repeat (10) @(posedge clk);
    #1;
    reset_n = 1'b1;
    tick();
    check("rst_ready", 64'(bus.task_ready), 64'd1);
    check("rst_request", 64'(bus.core_request), 64'd0);
    check("rst_start", 64'(bus.core_start), 64'd0);
    check("rst_task", 64'(bus.core_task), 64'd0);
    check("rst_release", 64'(bus.core_release), 64'd0);
    check("rst_rel_id", 64'(bus.released_core_id), 64'd0);
    check("rst_busy", 64'(bus.busy_mask), 64'd0);

    // Single task to core 2, then release it.
    dispatch(32'hDEAD_BEEF, 2'd2, 0, 4'b0100);
    bus.core_done = 4'b0100;
    tick();
    bus.core_done = '0;
    check("rel2_valid", 64'(bus.core_release), 64'd1);
    check("rel2_id", 64'(bus.released_core_id), 64'd2);
    check("rel2_busy", 64'(bus.busy_mask), 64'd0);
    tick();
    check("rel2_single", 64'(bus.core_release), 64'd0);

    // Three tasks, then simultaneous done on cores 0 and 2.
    dispatch(32'h1111_0000, 2'd0, 0, 4'b0001);
    dispatch(32'h2222_0001, 2'd1, 0, 4'b0011);
    dispatch(32'h3333_0002, 2'd2, 0, 4'b0111);
    bus.core_done = 4'b0101;
    tick();
    bus.core_done = '0;
    check("multi_rel_a", 64'(bus.core_release), 64'd1);
    check("multi_id_a", 64'(bus.released_core_id), 64'd0);
    check("multi_busy_a", 64'(bus.busy_mask), 64'b0110);
    tick();
    check("multi_rel_b", 64'(bus.core_release), 64'd1);
    check("multi_id_b", 64'(bus.released_core_id), 64'd2);
    check("multi_busy_b", 64'(bus.busy_mask), 64'b0010);
    tick();
    check("multi_rel_end", 64'(bus.core_release), 64'd0);

    // Done from idle core 3 is dropped.
    bus.core_done = 4'b1000;
    tick();
    bus.core_done = '0;
    check("idle_done_rel", 64'(bus.core_release), 64'd0);
    tick();
    check("idle_done_rel_late", 64'(bus.core_release), 64'd0);
    check("idle_done_busy", 64'(bus.busy_mask), 64'b0010);

    // Stray grant in IDLE is ignored.
    bus.core_valid = 1'b1;
    bus.core_id    = 2'd3;
    tick();
    bus.core_valid = 1'b0;
    check("stray_start", 64'(bus.core_start), 64'd0);
    tick();
    check("stray_start_late", 64'(bus.core_start), 64'd0);
    check("stray_busy", 64'(bus.busy_mask), 64'b0010);
    check("stray_ready", 64'(bus.task_ready), 64'd1);

    // Grant delayed by 20 cycles.
    dispatch(32'hCAFE_F00D, 2'd3, 20, 4'b1010);

    // Reset asserted while waiting for a grant.
    bus.task_valid = 1'b1;
    bus.task_data  = 32'h0BAD_0BAD;
    tick();
    bus.task_valid = 1'b0;
    tick();
    check("pre_rst_wait_ready", 64'(bus.task_ready), 64'd0);
    #2;
    reset_n = 1'b0;
    #1;
    check("midrst_ready", 64'(bus.task_ready), 64'd1);
    check("midrst_busy", 64'(bus.busy_mask), 64'd0);
    check("midrst_request", 64'(bus.core_request), 64'd0);
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    tick();
    check("post_rst_ready", 64'(bus.task_ready), 64'd1);
    check("post_rst_task", 64'(bus.core_task), 64'd0);

`ifdef CORE_DISPATCH_STATS_EN
    check("stats_rst_disp", 64'(dispatch_count), 64'd0);
    check("stats_rst_rel", 64'(release_count), 64'd0);
    dispatch(32'hA000_0000, 2'd0, 0, 4'b0001);
    dispatch(32'hA000_0001, 2'd1, 1, 4'b0011);
    dispatch(32'hA000_0002, 2'd2, 0, 4'b0111);
    dispatch(32'hA000_0003, 2'd3, 2, 4'b1111);
    bus.core_done = 4'b1111;
    tick();
    bus.core_done = '0;
    repeat (4) tick();
    check("stats_busy", 64'(bus.busy_mask), 64'd0);
    check("stats_disp", 64'(dispatch_count), 64'd4);
    check("stats_rel", 64'(release_count), 64'd4);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
